mgmt_rx_frame_arbiter: RTL and testbench

// - Next-gen management RX path: merges N_PORTS per-port RX frame streams (already in sys_clk, from per-port

---
 rtl/mgmt_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/mgmt_rx_frame_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mgmt_rx_frame_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_pkg.sv
// ---------------------------------------------------------------------------
// mgmt_pkg
// Shared types for the management RX frame path.
//   mgmt_hdr_t   : one-word frame header {rsvd, port, rsvd, len}
//   arb_state_e  : frame arbiter state encoding (exported on dbg_state)
//   MGMT_MAX_PORTS: upper bound on ingress ports (port field is 4 bits)
//   mk_hdr()     : builds a header word from port index and byte length
// ---------------------------------------------------------------------------
package mgmt_pkg;

   localparam int MGMT_MAX_PORTS = 16;

   typedef struct packed {
      logic [3:0]  rsvd_hi;
      logic [3:0]  port;
      logic [7:0]  rsvd_lo;
      logic [15:0] len;
   } mgmt_hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DROP    = 2'd3
   } arb_state_e;

   function automatic mgmt_hdr_t mk_hdr(input logic [3:0] port, input logic [15:0] len);
      mgmt_hdr_t h;
      h.rsvd_hi = 4'h0;
      h.port    = port;
      h.rsvd_lo = 8'h00;
      h.len     = len;
      return h;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: grants the first requester at or after
// ptr_i, wrapping modulo N.
//   req_i         in  N   request vector
//   ptr_i         in  IW  highest-priority index this round (must be < N)
//   grant_oh_o    out N   one-hot grant
//   grant_idx_o   out IW  index of the granted requester
//   grant_valid_o out 1   at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_oh_o,
   output logic [IW-1:0] grant_idx_o,
   output logic          grant_valid_o
);

   // One spare bit so ptr + offset can be wrapped without overflow.
   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      grant_oh_o    = '0;
      grant_idx_o   = '0;
      grant_valid_o = 1'b0;
      sum           = '0;
      idx           = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_i} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         idx = sum[IW-1:0];
         if (!grant_valid_o && req_i[idx]) begin
            grant_valid_o    = 1'b1;
            grant_idx_o      = idx;
            grant_oh_o[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mgmt_rx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// mgmt_rx_frame_arbiter
// Merges N_PORTS management RX frame streams into one CPU-facing stream with
// whole-frame round-robin arbitration. Each forwarded frame is preceded by a
// header word {4'h0, port, 8'h00, len}. Oversize (len > MAX_LEN) and empty
// frames are drained from the port and counted as drops.
//
// Handshake: a word moves on a channel in any cycle where valid & ready are
// both high at the rising clock edge; a source never withdraws or alters a
// word while valid is high and ready is low.
//
// Ports
//   sys_clk, sys_rst             clock, async active-high reset
//   port_link_up   [N]           ports with link down are never granted
//   in_frame_avail [N]           a complete frame is buffered on the port
//   in_frame_len   [N*16]        byte length of each port's head frame
//   in_valid/in_data/in_last     per-port payload words (first byte [31:24])
//   in_ready       [N]           payload accept, only to the granted port
//   out_valid/out_ready          CPU-side stream handshake
//   out_data/out_header/out_last header or payload word with markers
//   stat_sel       [4]           port index for statistics readout
//   stat_frames/stat_drops       registered counters of stat_sel port
//   dbg_state      [2]           arbiter FSM state (arb_state_e)
// ---------------------------------------------------------------------------
module mgmt_rx_frame_arbiter
   import mgmt_pkg::*;
#(
   parameter int N_PORTS   = 4,
   parameter int MAX_LEN   = 1518,
   parameter int CNT_WIDTH = 32
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [N_PORTS-1:0]     port_link_up,
   input  logic [N_PORTS-1:0]     in_frame_avail,
   input  logic [N_PORTS*16-1:0]  in_frame_len,
   input  logic [N_PORTS-1:0]     in_valid,
   input  logic [N_PORTS*32-1:0]  in_data,
   input  logic [N_PORTS-1:0]     in_last,
   output logic [N_PORTS-1:0]     in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic                   out_header,
   output logic                   out_last,
   input  logic [3:0]             stat_sel,
   output logic [CNT_WIDTH-1:0]   stat_frames,
   output logic [CNT_WIDTH-1:0]   stat_drops,
   output logic [1:0]             dbg_state
);

   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   arb_state_e           state_q;
   logic [PW-1:0]        gnt_q;
   logic [N_PORTS-1:0]   gnt_oh_q;
   logic [PW-1:0]        rr_q;
   mgmt_hdr_t            hdr_q;

   logic [N_PORTS-1:0]   eligible;
   logic [N_PORTS-1:0]   arb_oh;
   logic [PW-1:0]        arb_idx;
   logic                 arb_valid;
   logic [15:0]          arb_len;
   logic                 len_bad;

   logic                 g_valid;
   logic                 g_last;
   logic [31:0]          g_data;
   logic                 frame_done;
   logic                 drop_done;
   logic [PW-1:0]        rr_next;

   logic [CNT_WIDTH-1:0] frames_q [N_PORTS];
   logic [CNT_WIDTH-1:0] drops_q  [N_PORTS];
   logic [CNT_WIDTH-1:0] stat_frames_q;
   logic [CNT_WIDTH-1:0] stat_drops_q;

   assign eligible = in_frame_avail & port_link_up;

   rr_arbiter #(.N(N_PORTS), .IW(PW)) u_rr (
      .req_i         (eligible),
      .ptr_i         (rr_q),
      .grant_oh_o    (arb_oh),
      .grant_idx_o   (arb_idx),
      .grant_valid_o (arb_valid)
   );

   // Length of the candidate port's head frame, sampled only in IDLE.
   always_comb begin
      arb_len = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (arb_idx == PW'(p)) begin
            arb_len = in_frame_len[p*16 +: 16];
         end
      end
   end

   assign len_bad = (arb_len == 16'd0) || ({16'd0, arb_len} > 32'(MAX_LEN));

   // Payload side of the port currently holding the grant.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         if (gnt_q == PW'(p)) begin
            g_valid = in_valid[p];
            g_last  = in_last[p];
            g_data  = in_data[p*32 +: 32];
         end
      end
   end

   assign frame_done = (state_q == ST_PAYLOAD) && g_valid && out_ready && g_last;
   assign drop_done  = (state_q == ST_DROP) && g_valid && g_last;
   assign rr_next    = (gnt_q == PW'(N_PORTS-1)) ? '0 : gnt_q + 1'b1;

   // Arbiter FSM. Grant, one-hot grant and header are latched once in IDLE,
   // so length/link changes after the grant have no effect on this frame.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= ST_IDLE;
         gnt_q    <= '0;
         gnt_oh_q <= '0;
         rr_q     <= '0;
         hdr_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  gnt_q    <= arb_idx;
                  gnt_oh_q <= arb_oh;
                  hdr_q    <= mk_hdr(4'(arb_idx), arb_len);
                  state_q  <= len_bad ? ST_DROP : ST_HEADER;
               end
            end
            ST_HEADER: begin
               if (out_ready) begin
                  state_q <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               if (frame_done) begin
                  rr_q    <= rr_next;
                  state_q <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (drop_done) begin
                  rr_q    <= rr_next;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Output and upstream-ready steering. Payload is a straight combinational
   // pass-through so there is no bubble between header and first word.
   always_comb begin
      out_valid  = 1'b0;
      out_header = 1'b0;
      out_last   = 1'b0;
      out_data   = '0;
      in_ready   = '0;
      case (state_q)
         ST_HEADER: begin
            out_valid  = 1'b1;
            out_header = 1'b1;
            out_data   = hdr_q;
         end
         ST_PAYLOAD: begin
            out_valid = g_valid;
            out_last  = g_last;
            out_data  = g_data;
            in_ready  = gnt_oh_q & {N_PORTS{out_ready}};
         end
         ST_DROP: begin
            in_ready = gnt_oh_q;
         end
         default: ;
      endcase
   end

   // Saturating per-port frame and drop counters.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int p = 0; p < N_PORTS; p++) begin
            frames_q[p] <= '0;
            drops_q[p]  <= '0;
         end
      end else begin
         if (frame_done && (frames_q[gnt_q] != '1)) begin
            frames_q[gnt_q] <= frames_q[gnt_q] + 1'b1;
         end
         if (drop_done && (drops_q[gnt_q] != '1)) begin
            drops_q[gnt_q] <= drops_q[gnt_q] + 1'b1;
         end
      end
   end

   // Registered statistics readout; out-of-range selects read as zero.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         stat_frames_q <= '0;
         stat_drops_q  <= '0;
      end else if ({28'd0, stat_sel} < 32'(N_PORTS)) begin
         stat_frames_q <= frames_q[stat_sel[PW-1:0]];
         stat_drops_q  <= drops_q[stat_sel[PW-1:0]];
      end else begin
         stat_frames_q <= '0;
         stat_drops_q  <= '0;
      end
   end

   assign stat_frames = stat_frames_q;
   assign stat_drops  = stat_drops_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mgmt_rx_frame_arbiter.sv
module tb_mgmt_rx_frame_arbiter;

   localparam int NP     = 4;
   localparam int MAXF   = 64;
   localparam int MAXLEN = 1518;

   // ---------------- clock / reset ----------------
   logic sys_clk = 1'b0;
   logic sys_rst;
   always #5 sys_clk = ~sys_clk;

   // ---------------- DUT signals ----------------
   logic [NP-1:0]    port_link_up;
   logic [NP-1:0]    in_frame_avail;
   logic [NP*16-1:0] in_frame_len;
   logic [NP-1:0]    in_valid;
   logic [NP*32-1:0] in_data;
   logic [NP-1:0]    in_last;
   logic [NP-1:0]    in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic             out_header;
   logic             out_last;
   logic [3:0]       stat_sel;
   logic [31:0]      stat_frames;
   logic [31:0]      stat_drops;
   logic [1:0]       dbg_state;

   logic        src_avail [NP];
   logic        src_valid [NP];
   logic        src_last  [NP];
   logic [15:0] src_len   [NP];
   logic [31:0] src_data  [NP];

   assign in_frame_avail = {src_avail[3], src_avail[2], src_avail[1], src_avail[0]};
   assign in_valid       = {src_valid[3], src_valid[2], src_valid[1], src_valid[0]};
   assign in_last        = {src_last[3], src_last[2], src_last[1], src_last[0]};
   assign in_frame_len   = {src_len[3], src_len[2], src_len[1], src_len[0]};
   assign in_data        = {src_data[3], src_data[2], src_data[1], src_data[0]};

   mgmt_rx_frame_arbiter #(.N_PORTS(NP), .MAX_LEN(MAXLEN), .CNT_WIDTH(32)) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .port_link_up   (port_link_up),
      .in_frame_avail (in_frame_avail),
      .in_frame_len   (in_frame_len),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_header     (out_header),
      .out_last       (out_last),
      .stat_sel       (stat_sel),
      .stat_frames    (stat_frames),
      .stat_drops     (stat_drops),
      .dbg_state      (dbg_state)
   );

   // ---------------- bench state ----------------
   int n_vec = 0;
   int n_err = 0;

   // Upstream frame queues per port: lengths, head pointer, word cursor.
   int frm_len [NP][MAXF];
   int head    [NP];
   int cnt     [NP];
   int widx    [NP];
   bit hold    [NP];
   bit acc_now [NP];
   int acc_words [NP];

   // Reference model results.
   logic [33:0] exp_q [$];
   int exp_words  [NP];
   int exp_frames [NP];
   int exp_drops  [NP];
   int exp_rr;

   int vprob;
   int rmode;
   int cyc_g;
   bit prev_stall;
   logic [33:0] prev_word;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- helpers ----------------
   function automatic int nwords(input int len);
      return (len <= 0) ? 1 : (len + 3) / 4;
   endfunction

   function automatic logic [31:0] word_of(input int p, input int f, input int w);
      return {4'(p), 12'(f), 16'(w)};
   endfunction

   function automatic int rand_len();
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) return 0;
      if (r == 1) return int'($urandom_range(1519, 1600));
      if (r == 2) return MAXLEN;
      return int'($urandom_range(1, 160));
   endfunction

   function automatic bit all_done();
      if (exp_q.size() != 0) return 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (acc_words[p] != exp_words[p]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic add_frame(input int p, input int len);
      frm_len[p][cnt[p]] = len;
      cnt[p]++;
   endtask

   // Reference model: serve every pending frame on linked ports in
   // round-robin order starting at exp_rr, one whole frame per turn.
   task automatic plan();
      int ph [NP];
      int p;
      int len;
      bit found;
      for (int i = 0; i < NP; i++) ph[i] = head[i];
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         p = 0;
         for (int k = 0; k < NP; k++) begin
            if (!found && port_link_up[(exp_rr + k) % NP] && (ph[(exp_rr + k) % NP] < cnt[(exp_rr + k) % NP])) begin
               found = 1'b1;
               p = (exp_rr + k) % NP;
            end
         end
         if (found) begin
            len = frm_len[p][ph[p]];
            exp_words[p] += nwords(len);
            if (len == 0 || len > MAXLEN) begin
               exp_drops[p]++;
            end else begin
               exp_q.push_back({1'b1, 1'b0, 4'h0, 4'(p), 8'h00, 16'(len)});
               for (int w = 0; w < nwords(len); w++) begin
                  exp_q.push_back({1'b0, (w == nwords(len) - 1), word_of(p, ph[p], w)});
               end
               exp_frames[p]++;
            end
            ph[p]++;
            exp_rr = (p + 1) % NP;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         if (head[p] < cnt[p]) begin
            src_avail[p] = 1'b1;
            src_len[p]   = 16'(frm_len[p][head[p]]);
            if (!hold[p]) src_valid[p] = ($urandom_range(0, 99) < vprob);
            src_data[p]  = word_of(p, head[p], widx[p]);
            src_last[p]  = (widx[p] == nwords(frm_len[p][head[p]]) - 1);
         end else begin
            src_avail[p] = 1'b0;
            src_len[p]   = '0;
            src_valid[p] = 1'b0;
            src_data[p]  = '0;
            src_last[p]  = 1'b0;
         end
      end
      case (rmode)
         0: out_ready = 1'b1;
         1: out_ready = (cyc_g % 2 == 0);
         default: out_ready = ($urandom_range(0, 99) < 70);
      endcase
      cyc_g++;
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic sample();
      logic [33:0] w;
      logic [33:0] e;
      w = {out_header, out_last, out_data};
      if (prev_stall) check("stall_hold", 64'({out_valid, w}), 64'({1'b1, prev_word}));
      prev_stall = out_valid && !out_ready;
      prev_word  = w;
      if (out_valid && out_ready) begin
         check("word_expected", 64'(exp_q.size() > 0), 64'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_word", 64'(w), 64'(e));
         end
      end
      for (int p = 0; p < NP; p++) begin
         acc_now[p] = src_valid[p] && in_ready[p];
         hold[p]    = src_valid[p] && !in_ready[p];
      end
   endtask

   task automatic step();
      drive();
      #4;
      sample();
      @(posedge sys_clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (acc_now[p]) begin
            acc_words[p]++;
            widx[p]++;
            if (widx[p] == nwords(frm_len[p][head[p]])) begin
               widx[p] = 0;
               head[p]++;
            end
         end
      end
   endtask

   task automatic read_stats(input string name);
      for (int p = 0; p <= NP; p++) begin
         stat_sel = 4'(p);
         @(posedge sys_clk);
         #1;
         if (p < NP) begin
            check($sformatf("%s_frames_p%0d", name, p), 64'(stat_frames), 64'(exp_frames[p]));
            check($sformatf("%s_drops_p%0d", name, p), 64'(stat_drops), 64'(exp_drops[p]));
         end else begin
            check($sformatf("%s_frames_oob", name), 64'(stat_frames), 64'(0));
            check($sformatf("%s_drops_oob", name), 64'(stat_drops), 64'(0));
         end
      end
   endtask

   task automatic run(input string name, input int budget, input int drop_cyc);
      int c;
      c = 0;
      while (!all_done() && c < budget) begin
         if (c == drop_cyc) port_link_up[0] = 1'b0;
         step();
         c++;
      end
      check($sformatf("%s_drained", name), 64'(all_done()), 64'(1));
      repeat (2) step();
      for (int p = 0; p < NP; p++) begin
         check($sformatf("%s_words_p%0d", name, p), 64'(acc_words[p]), 64'(exp_words[p]));
      end
      check($sformatf("%s_leftover", name), 64'(exp_q.size()), 64'(0));
      read_stats(name);
   endtask

   task automatic clear_model();
      for (int p = 0; p < NP; p++) begin
         head[p] = 0; cnt[p] = 0; widx[p] = 0; hold[p] = 1'b0; acc_now[p] = 1'b0;
         acc_words[p] = 0; exp_words[p] = 0; exp_frames[p] = 0; exp_drops[p] = 0;
         src_avail[p] = 1'b0; src_valid[p] = 1'b0; src_last[p] = 1'b0;
         src_len[p] = '0; src_data[p] = '0;
      end
      exp_q.delete();
      exp_rr = 0;
      prev_stall = 1'b0;
      prev_word = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      sys_rst      = 1'b1;
      out_ready    = 1'b0;
      stat_sel     = '0;
      port_link_up = 4'hF;
      vprob        = 100;
      rmode        = 0;
      cyc_g        = 0;
      clear_model();

      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_header", 64'(out_header), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_stat_frames", 64'(stat_frames), 64'(0));
      check("rst_stat_drops", 64'(stat_drops), 64'(0));
      sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;

      // Single 64-byte frame on port 0, header one cycle after availability.
      add_frame(0, 64);
      plan();
      drive();
      @(posedge sys_clk);
      #1;
      check("t1_hdr_latency", 64'({out_valid, out_header}), 64'(2'b11));
      check("t1_hdr_word", 64'(out_data), 64'(32'h0000_0040));
      run("t1", 2000, -1);

      // Two ports at once: round-robin order decides.
      add_frame(0, 32);
      add_frame(2, 48);
      plan();
      run("t2", 2000, -1);

      // Oversize, boundary and empty frames.
      add_frame(1, 2000);
      add_frame(2, MAXLEN);
      add_frame(0, MAXLEN + 1);
      add_frame(3, 0);
      plan();
      run("t3", 8000, -1);

      // Port 3 link down: its frames must stay untouched.
      port_link_up = 4'b0111;
      add_frame(3, 40);
      add_frame(0, 20);
      add_frame(3, 44);
      plan();
      run("t4", 2000, -1);
      check("t4_p3_untouched", 64'(acc_words[3]), 64'(exp_words[3]));
      check("t4_p3_pending", 64'(cnt[3] - head[3]), 64'(2));

      // Link restored plus out_ready toggling every cycle.
      port_link_up = 4'hF;
      rmode = 1;
      add_frame(1, 40);
      plan();
      run("t5", 4000, -1);

      // Link falls mid-frame on port 0; frame still completes.
      rmode = 0;
      add_frame(0, 40);
      plan();
      run("t6", 2000, 4);
      port_link_up = 4'hF;

      // Randomized rounds.
      for (int r = 0; r < 6; r++) begin
         rmode = r % 3;
         vprob = int'($urandom_range(50, 100));
         port_link_up = 4'($urandom_range(1, 15));
         for (int p = 0; p < NP; p++) begin
            int nf;
            nf = int'($urandom_range(0, 3));
            for (int f = 0; f < nf; f++) add_frame(p, rand_len());
         end
         plan();
         run($sformatf("rnd%0d", r), 20000, -1);
      end

      // Flush anything left on ports that were down.
      port_link_up = 4'hF;
      rmode = 2;
      plan();
      run("flush", 20000, -1);

      // Reset in the middle of a payload.
      rmode = 0;
      vprob = 100;
      stat_sel = 4'd0;
      add_frame(1, 256);
      plan();
      for (int k = 0; k < 6; k++) step();
      sys_rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'(0));
      check("mid_rst_in_ready", 64'(in_ready), 64'(0));
      check("mid_rst_stat_frames", 64'(stat_frames), 64'(0));
      check("mid_rst_stat_drops", 64'(stat_drops), 64'(0));
      clear_model();
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;
      add_frame(2, 8);
      plan();
      run("post_rst", 2000, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
